sdram_frame_arbiter: RTL and testbench

Three-requester Avalon-MM arbiter sharing the single SDRAM controller port between the display frame reader, the camera frame writer and the Nios CPU data master. It sits between the VIP frame-buffer masters and the SDRAM controller slave. It grants bounded bursts in round-robin order and gives the display reader urgent priority to prevent clocked-video underflow. Pipelined read returns are routed back to their issuer through an in-order tag FIFO.

---
 rtl/sdram_frame_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_frame_arbiter
//   Shares one Avalon-MM SDRAM controller port between three masters:
//   display frame reader (id 0), camera frame writer (id 1) and CPU data
//   master (id 2). Bursts are bounded to MAX_BURST accepted transfers per
//   grant and rotate round-robin. An urgent display read wins arbitration
//   and cuts short a burst owned by another master. Read returns are routed
//   back to their issuer through an in-order tag FIFO.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   d_*                            display reader (read-only) + d_urgent
//   c_*                            camera writer (write-only)
//   p_*                            CPU master (read/write, byteenable)
//   s_*                            command/return toward the SDRAM controller
//   err_orphan                     sticky: return arrived with no read pending
// -----------------------------------------------------------------------------
module sdram_frame_arbiter #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // display reader
  input  logic [ADDR_W-1:0]     d_address,
  input  logic                  d_read,
  input  logic                  d_urgent,
  output logic                  d_waitrequest,
  output logic [DATA_W-1:0]     d_readdata,
  output logic                  d_readdatavalid,
  // camera writer
  input  logic [ADDR_W-1:0]     c_address,
  input  logic                  c_write,
  input  logic [DATA_W-1:0]     c_writedata,
  output logic                  c_waitrequest,
  // CPU data master
  input  logic [ADDR_W-1:0]     p_address,
  input  logic                  p_read,
  input  logic                  p_write,
  input  logic [DATA_W-1:0]     p_writedata,
  input  logic [DATA_W/8-1:0]   p_byteenable,
  output logic                  p_waitrequest,
  output logic [DATA_W-1:0]     p_readdata,
  output logic                  p_readdatavalid,
  // SDRAM controller slave
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_readdatavalid,
  // status
  output logic                  err_orphan
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PTR_W = $clog2(MAX_PENDING);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] ID_D = 2'd0;
  localparam logic [1:0] ID_C = 2'd1;
  localparam logic [1:0] ID_P = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             state;
  state_t             nxt_state;

  logic [1:0]         grant;
  logic [1:0]         last;
  logic [1:0]         pick;
  logic [1:0]         rr1;
  logic [1:0]         rr2;
  logic [CNT_W-1:0]   count;

  logic [2:0]         req;
  logic               d_hot;
  logic               own_rd;
  logic               own_wr;
  logic               own_wait;
  logic               accept;
  logic               push;
  logic               pop;
  logic               tag_full;
  logic               owner_done;

  logic [LVL_W-1:0]   level;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [1:0]         tag_mem [MAX_PENDING];
  logic [1:0]         pop_id;
  logic [DATA_W-1:0]  rdata_q;

  function automatic logic is_req(input logic [1:0] id, input logic [2:0] r);
    case (id)
      2'd0:    return r[0];
      2'd1:    return r[1];
      default: return r[2];
    endcase
  endfunction

  // Arbitration: urgent display first, else first requester after last owner
  always_comb begin
    req   = {p_read | p_write, c_write, d_read};
    d_hot = d_read & d_urgent;
    rr1   = (last == ID_P) ? ID_D : last + 2'd1;
    rr2   = (rr1 == ID_P) ? ID_D : rr1 + 2'd1;
    if (d_hot)                 pick = ID_D;
    else if (is_req(rr1, req)) pick = rr1;
    else if (is_req(rr2, req)) pick = rr2;
    else                       pick = last;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (|req) nxt_state = OWN;
      OWN:     if (owner_done) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Output logic: command mux, waitrequests, acceptance and burst exit
  always_comb begin
    s_address     = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = '0;
    s_byteenable  = '0;
    d_waitrequest = 1'b1;
    c_waitrequest = 1'b1;
    p_waitrequest = 1'b1;
    own_rd        = 1'b0;
    own_wr        = 1'b0;
    own_wait      = 1'b1;
    accept        = 1'b0;
    push          = 1'b0;
    owner_done    = 1'b0;

    if (state == OWN) begin
      case (grant)
        ID_D: begin
          own_rd       = d_read;
          s_address    = d_address;
          s_byteenable = '1;
        end
        ID_C: begin
          own_wr       = c_write;
          s_address    = c_address;
          s_writedata  = c_writedata;
          s_byteenable = '1;
        end
        default: begin
          // a simultaneous read+write from the CPU is treated as a write
          own_rd       = p_read & ~p_write;
          own_wr       = p_write;
          s_address    = p_address;
          s_writedata  = p_writedata;
          s_byteenable = p_byteenable;
        end
      endcase

      // reads stall while every tag slot holds an outstanding read
      s_read   = own_rd & ~tag_full;
      s_write  = own_wr;
      own_wait = s_waitrequest | (own_rd & tag_full);

      case (grant)
        ID_D:    d_waitrequest = own_wait;
        ID_C:    c_waitrequest = own_wait;
        default: p_waitrequest = own_wait;
      endcase

      accept     = (s_read | s_write) & ~s_waitrequest;
      push       = accept & s_read;
      owner_done = ~(own_rd | own_wr)
                 | (accept & (count == CNT_W'(MAX_BURST - 1)))
                 | (accept & (grant != ID_D) & d_hot);
    end
  end

  // Grant, rotation pointer and burst counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= ID_D;
      last  <= ID_P;
      count <= '0;
    end else begin
      if ((state == IDLE) && (|req)) begin
        grant <= pick;
        count <= '0;
      end else if (accept) begin
        count <= count + CNT_W'(1);
      end
      if (owner_done) last <= grant;
    end
  end

  // In-order read tag FIFO
  assign tag_full = (level == LVL_W'(MAX_PENDING));
  assign pop      = s_readdatavalid & (level != '0);
  assign pop_id   = tag_mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Tag storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  // Return path: one register stage, valid steered by the popped tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q         <= '0;
      d_readdatavalid <= 1'b0;
      p_readdatavalid <= 1'b0;
      err_orphan      <= 1'b0;
    end else begin
      d_readdatavalid <= pop & (pop_id == ID_D);
      p_readdatavalid <= pop & (pop_id == ID_P);
      if (pop) rdata_q <= s_readdata;
      if (s_readdatavalid & (level == '0)) err_orphan <= 1'b1;
    end
  end

  assign d_readdata = rdata_q;
  assign p_readdata = rdata_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
module tb_sdram_frame_arbiter;

  localparam int unsigned ADDR_W      = 24;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned MAX_BURST   = 8;
  localparam int unsigned MAX_PENDING = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] d_address, c_address, p_address, s_address;
  logic              d_read, d_urgent, d_waitrequest, d_readdatavalid;
  logic [DATA_W-1:0] d_readdata, p_readdata, c_writedata, p_writedata, s_writedata, s_readdata;
  logic              c_write, c_waitrequest;
  logic              p_read, p_write, p_waitrequest, p_readdatavalid;
  logic [1:0]        p_byteenable, s_byteenable;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic              err_orphan;

  sdram_frame_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk), .reset(reset),
    .d_address(d_address), .d_read(d_read), .d_urgent(d_urgent),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata), .d_readdatavalid(d_readdatavalid),
    .c_address(c_address), .c_write(c_write), .c_writedata(c_writedata),
    .c_waitrequest(c_waitrequest),
    .p_address(p_address), .p_read(p_read), .p_write(p_write), .p_writedata(p_writedata),
    .p_byteenable(p_byteenable), .p_waitrequest(p_waitrequest), .p_readdata(p_readdata),
    .p_readdatavalid(p_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic idle_in();
    d_address = '0; d_read = 0; d_urgent = 0;
    c_address = '0; c_write = 0; c_writedata = '0;
    p_address = '0; p_read = 0; p_write = 0; p_writedata = '0; p_byteenable = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] wd_of(input int k);
    return 16'(32'h1234 + k * 32'h0101);
  endfunction

  // Directed arbitration vectors: in = {d_read,d_urgent,c_write,p_read,p_write,s_wait}
  // exp = {s_read,s_write,d_wait,c_wait,p_wait}
  typedef struct packed {
    logic [5:0]  in;
    logic [4:0]  exp;
    logic [23:0] addr;
  } vec_t;

  localparam logic [23:0] AD = 24'h0D0000;
  localparam logic [23:0] AC = 24'h0C0000;
  localparam logic [23:0] AP = 24'h0A0000;

  vec_t tbl [15];

  // Reference model state (random phase)
  int          m_owner;
  int          m_last;
  int          m_cnt;
  int          tagq [$];
  logic        e_drdv, e_prdv, e_orphan;
  logic [15:0] e_rdata;

  function automatic bit req_of(input int id);
    case (id)
      0:       return d_read;
      1:       return c_write;
      default: return p_read || p_write;
    endcase
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int acc_cyc [10];

    tbl[0]  = {6'b000000, 5'b00111, 24'h0};
    tbl[1]  = {6'b001010, 5'b00111, 24'h0};
    tbl[2]  = {6'b001010, 5'b01101, AC};
    tbl[3]  = {6'b000010, 5'b00101, AC};
    tbl[4]  = {6'b000010, 5'b00111, 24'h0};
    tbl[5]  = {6'b000011, 5'b01111, AP};
    tbl[6]  = {6'b110010, 5'b01110, AP};
    tbl[7]  = {6'b111010, 5'b00111, 24'h0};
    tbl[8]  = {6'b101000, 5'b10011, AD};
    tbl[9]  = {6'b001000, 5'b00011, AD};
    tbl[10] = {6'b001000, 5'b00111, 24'h0};
    tbl[11] = {6'b001110, 5'b01101, AC};
    tbl[12] = {6'b000100, 5'b00101, AC};
    tbl[13] = {6'b000110, 5'b00111, 24'h0};
    tbl[14] = {6'b000110, 5'b01110, AP};

    reset = 1'b1;
    idle_in();

    // ---- reset values and idle masters
    do_reset();
    #1;
    chk("rst_cmd", {s_read, s_write}, 2'b00);
    chk("rst_addr", s_address, 0);
    chk("rst_wdata_be", {s_writedata, s_byteenable}, 0);
    chk("rst_wait", {d_waitrequest, c_waitrequest, p_waitrequest}, 3'b111);
    chk("rst_rdv", {d_readdatavalid, p_readdatavalid, err_orphan}, 3'b000);
    chk("rst_rdata", {d_readdata, p_readdata}, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_cmd", {s_read, s_write, d_waitrequest, c_waitrequest, p_waitrequest}, 5'b00111);

    // ---- table-driven arbitration vectors
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      {d_read, d_urgent, c_write, p_read, p_write, s_waitrequest} = tbl[i].in;
      d_address = AD; c_address = AC; p_address = AP;
      #1;
      chk($sformatf("tbl%0d_ctl", i),
          {s_read, s_write, d_waitrequest, c_waitrequest, p_waitrequest}, tbl[i].exp);
      chk($sformatf("tbl%0d_addr", i), s_address, tbl[i].addr);
    end

    // ---- camera writes 20 words: bursts of 8, 8, 4 with a one-cycle gap
    do_reset();
    k = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      c_write     = (k < 20);
      c_writedata = wd_of(k);
      c_address   = 24'(32'h200 + k);
      #1;
      if (c_write && !c_waitrequest) begin
        chk($sformatf("cam_wd%0d", k), {s_write, s_writedata}, {1'b1, wd_of(k)});
        chk($sformatf("cam_cyc%0d", k), cyc, 1 + k + k / 8);
        k++;
      end
    end
    chk("cam_count", k, 20);

    // ---- urgent display preempts a camera burst
    do_reset();
    k = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      c_write = 1; c_writedata = wd_of(cyc); c_address = AC;
      d_read = (cyc >= 4); d_urgent = (cyc >= 4); d_address = AD;
      #1;
      if (c_write && !c_waitrequest) k++;
      if (cyc == 4) chk("pre_last_acc", {s_write, c_waitrequest}, 2'b10);
      if (cyc == 5) chk("pre_gap", {s_read, s_write, d_waitrequest, c_waitrequest}, 4'b0011);
      if (cyc == 6) begin
        chk("pre_disp", {s_read, s_write, d_waitrequest, c_waitrequest}, 4'b1001);
        chk("pre_disp_addr", s_address, AD);
      end
    end
    chk("pre_cam_count", k, 4);

    // ---- CPU issues 10 reads with returns held off: tag FIFO fills at 8
    do_reset();
    k = 0;
    for (int cyc = 0; cyc < 31; cyc++) begin
      @(negedge clk);
      chk($sformatf("tf_prdv%0d", cyc), {d_readdatavalid, p_readdatavalid},
          {1'b0, (cyc >= 16 && cyc <= 23)});
      if (cyc >= 16 && cyc <= 23)
        chk($sformatf("tf_rdata%0d", cyc), p_readdata, 16'(32'hA500 + cyc - 16));
      p_read          = (k < 10);
      p_address       = 24'(32'h3000 + k);
      s_readdatavalid = (cyc >= 15 && cyc <= 22);
      s_readdata      = 16'(32'hA500 + cyc - 15);
      #1;
      if (cyc >= 10 && cyc <= 14)
        chk($sformatf("tf_stall%0d", cyc), {s_read, p_waitrequest}, 2'b01);
      if (p_read && !p_waitrequest) begin
        chk($sformatf("tf_addr%0d", k), {s_read, s_address}, {1'b1, 24'(32'h3000 + k)});
        if (k < 10) acc_cyc[k] = cyc;
        k++;
      end
    end
    chk("tf_count", k, 10);
    for (int i = 0; i < 10; i++)
      if (i < k) chk($sformatf("tf_acc_cyc%0d", i), acc_cyc[i], (i < 8) ? 1 + i : 8 + i);

    // ---- spurious return with empty FIFO
    do_reset();
    @(negedge clk);
    s_readdatavalid = 1; s_readdata = 16'hBEEF;
    @(negedge clk);
    s_readdatavalid = 0;
    chk("orph_set", {err_orphan, d_readdatavalid, p_readdatavalid}, 3'b100);
    repeat (3) @(negedge clk);
    chk("orph_sticky", err_orphan, 1);

    // ---- reset mid-burst: bus drops at once, in-flight returns become orphans
    do_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      p_read = 1; p_address = 24'(32'h4000 + cyc);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_bus", {s_read, s_write, p_waitrequest}, 3'b001);
    chk("mid_rst_addr", s_address, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_in();
    chk("mid_rst_orph0", err_orphan, 0);
    @(negedge clk);
    s_readdatavalid = 1; s_readdata = 16'h5A5A;
    @(negedge clk);
    s_readdatavalid = 0;
    chk("mid_rst_orph1", {err_orphan, p_readdatavalid}, 2'b10);

    // ---- randomized traffic against the reference model
    do_reset();
    m_owner = -1; m_last = 2; m_cnt = 0; tagq.delete();
    e_drdv = 0; e_prdv = 0; e_orphan = 0; e_rdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_rd, e_wr, e_sr, e_sw, full, acc, w;
      logic [2:0]  e_wait;
      logic [23:0] e_addr;
      logic [15:0] e_wd;
      logic [1:0]  e_be;
      int          o, pct;
      bit          found;

      @(negedge clk);
      chk("rnd_rdv", {d_readdatavalid, p_readdatavalid, err_orphan}, {e_drdv, e_prdv, e_orphan});
      if (e_drdv) chk("rnd_drdata", d_readdata, e_rdata);
      if (e_prdv) chk("rnd_prdata", p_readdata, e_rdata);

      d_read        = ($urandom_range(99) < 50);
      d_urgent      = ($urandom_range(99) < 20);
      c_write       = ($urandom_range(99) < 50);
      p_read        = ($urandom_range(99) < 40);
      p_write       = ($urandom_range(99) < 30);
      s_waitrequest = ($urandom_range(99) < 25);
      d_address     = 24'($urandom); c_address = 24'($urandom); p_address = 24'($urandom);
      c_writedata   = 16'($urandom); p_writedata = 16'($urandom); p_byteenable = 2'($urandom);
      s_readdata    = 16'($urandom);
      pct           = (cyc < 1500) ? 15 : 55;
      if (cyc < 2000) s_readdatavalid = (tagq.size() > 0) && ($urandom_range(99) < pct);
      else            s_readdatavalid = ($urandom_range(99) < 30);
      #1;

      o = m_owner;
      full = (tagq.size() == MAX_PENDING);
      e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0; e_be = '0;
      if (o == 0) begin
        e_rd = d_read; e_addr = d_address; e_be = 2'b11;
      end else if (o == 1) begin
        e_wr = c_write; e_addr = c_address; e_wd = c_writedata; e_be = 2'b11;
      end else if (o == 2) begin
        e_wr = p_write; e_rd = p_read && !p_write; e_addr = p_address;
        e_wd = p_writedata; e_be = p_byteenable;
      end
      e_sr = e_rd && !full;
      e_sw = e_wr;
      w = s_waitrequest || (e_rd && full);
      if (o == 0)      e_wait = {w, 2'b11};
      else if (o == 1) e_wait = {1'b1, w, 1'b1};
      else if (o == 2) e_wait = {2'b11, w};
      else             e_wait = 3'b111;

      chk("rnd_cmd", {s_read, s_write}, {e_sr, e_sw});
      chk("rnd_wait", {d_waitrequest, c_waitrequest, p_waitrequest}, e_wait);
      if (o >= 0) chk("rnd_addr", s_address, e_addr);
      if (e_sw) chk("rnd_wdata", s_writedata, e_wd);
      if (e_sr || e_sw) chk("rnd_be", s_byteenable, e_be);

      acc = (e_sr || e_sw) && !s_waitrequest;
      e_drdv = 0; e_prdv = 0;
      if (s_readdatavalid) begin
        if (tagq.size() > 0) begin
          int id;
          id = tagq.pop_front();
          e_rdata = s_readdata;
          e_drdv = (id == 0);
          e_prdv = (id == 2);
        end else begin
          e_orphan = 1;
        end
      end
      if (acc && e_sr) tagq.push_back(o);

      if (o < 0) begin
        if (d_read || c_write || p_read || p_write) begin
          if (d_read && d_urgent) m_owner = 0;
          else begin
            found = 0;
            for (int j = 1; j <= 3; j++) begin
              int id2;
              id2 = (m_last + j) % 3;
              if (!found && req_of(id2)) begin
                m_owner = id2;
                found = 1;
              end
            end
          end
          m_cnt = 0;
        end
      end else begin
        if (acc) m_cnt++;
        if ((!e_rd && !e_wr) || (acc && m_cnt == MAX_BURST) || (acc && o != 0 && d_read && d_urgent)) begin
          m_last  = o;
          m_owner = -1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
